// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM arbiter and its helpers.
// The default widths describe one 1 KiB text page of 8-bit character codes.
package vram_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    CPU_ACK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video fetch port, the CPU port and the RAM port around the arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_pkg::DEF_ADDR_W,
  parameter int DATA_W = vram_pkg::DEF_DATA_W
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output fetch_valid, fetch_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output fetch_req, fetch_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  fetch_valid, fetch_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/vram_wait_mon.sv
// Counts consecutive cycles a requester is held off and raises a sticky flag once
// the count saturates at MAX_WAIT. Meant to be reusable for other requesters.
module vram_wait_mon #(
  parameter int MAX_WAIT = vram_pkg::DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic grant,
  output logic starve
);

  localparam int               CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             starve_q;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
    count_d = '0;
    if (req && !grant) begin
      count_d = (count_q == LIMIT) ? count_q : count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      starve_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (count_d == LIMIT) starve_q <= 1'b1;
    end
  end

  assign starve = starve_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the raster fetch always wins, the CPU is served through a
// req/ack handshake at most every second cycle, and CPU lockout is flagged stickily.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,
  vram_arbiter_if.slave         bus,
  output logic                  cpu_starve
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              video_grant;
  logic              cpu_grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] rdata;
  logic              fetch_valid_q;
  logic              starve;

  // Grant decision; reset suppresses every grant so ram_we cannot pulse during reset.
  always_comb begin
    video_grant = 1'b0;
    cpu_grant   = 1'b0;
    state_d     = IDLE;
    grant_addr  = bus.cpu_addr;
    if (!reset) begin
      if (bus.fetch_req) begin
        video_grant = 1'b1;
        grant_addr  = bus.fetch_addr;
      end else if (state_q == IDLE && bus.cpu_req) begin
        cpu_grant = 1'b1;
        state_d   = CPU_ACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= video_grant;
    end
  end

  assign rdata         = bus.ram_rdata;

  assign bus.ram_addr  = grant_addr;
  assign bus.ram_we    = cpu_grant & bus.cpu_we;
  assign bus.ram_wdata = bus.cpu_wdata;

  // Responses are masked while reset is high so a pending ack/valid dies immediately.
  assign bus.fetch_valid = fetch_valid_q & ~reset;
  assign bus.fetch_data  = rdata;
  assign bus.cpu_ack     = (state_q == CPU_ACK) & ~reset;
  assign bus.cpu_rdata   = rdata;

  vram_wait_mon #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_mon (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.cpu_req),
    .grant  (cpu_grant),
    .starve (starve)
  );

  assign cpu_starve = starve & ~reset;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model with a shadow memory.
module tb_vram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;
  logic cpu_starve;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_starve (cpu_starve)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM attached to the arbiter's RAM port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(logic rst, logic fr, logic [AW-1:0] fa, logic cr, logic cw,
                       logic [AW-1:0] ca, logic [DW-1:0] cd);
    @(negedge clk);
    reset          = rst;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.cpu_req    = cr;
    bus.cpu_we     = cw;
    bus.cpu_addr   = ca;
    bus.cpu_wdata  = cd;
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          fr;
    logic [AW-1:0] fa;
    logic          cr;
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          e_fv;
    logic [DW-1:0] e_fd;
    logic          e_ack;
    logic          chk_rd;
    logic [DW-1:0] e_rd;
    logic          e_we;
    logic          chk_addr;
    logic [AW-1:0] e_addr;
    logic          e_starve;
  } vec_t;

  function automatic vec_t v(logic rst, logic fr, logic [AW-1:0] fa, logic cr, logic cw,
                             logic [AW-1:0] ca, logic [DW-1:0] cd, logic e_fv,
                             logic [DW-1:0] e_fd, logic e_ack, logic chk_rd,
                             logic [DW-1:0] e_rd, logic e_we, logic chk_addr,
                             logic [AW-1:0] e_addr, logic e_starve);
    vec_t r;
    r.rst = rst; r.fr = fr; r.fa = fa; r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.e_fv = e_fv; r.e_fd = e_fd; r.e_ack = e_ack; r.chk_rd = chk_rd; r.e_rd = e_rd;
    r.e_we = e_we; r.chk_addr = chk_addr; r.e_addr = e_addr; r.e_starve = e_starve;
    return r;
  endfunction

  // Reference model: a cycle-level view of the arbitration rules plus a shadow memory.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            m_prev_fetch, m_prev_cpu, m_prev_we, m_starve;
  int            m_run;
  logic [DW-1:0] m_fdata, m_cdata;

  task automatic model_reset();
    m_prev_fetch = 0; m_prev_cpu = 0; m_prev_we = 0; m_starve = 0; m_run = 0;
  endtask

  task automatic model_check(int n);
    bit vid, cpu, stalled;
    check($sformatf("rnd%0d fetch_valid", n), 32'(bus.fetch_valid), 32'(!reset && m_prev_fetch));
    check($sformatf("rnd%0d cpu_ack", n), 32'(bus.cpu_ack), 32'(!reset && m_prev_cpu));
    check($sformatf("rnd%0d cpu_starve", n), 32'(cpu_starve), 32'(!reset && m_starve));
    if (!reset && m_prev_fetch)
      check($sformatf("rnd%0d fetch_data", n), 32'(bus.fetch_data), 32'(m_fdata));
    if (!reset && m_prev_cpu && !m_prev_we)
      check($sformatf("rnd%0d cpu_rdata", n), 32'(bus.cpu_rdata), 32'(m_cdata));
    vid = !reset && bus.fetch_req;
    cpu = !reset && !bus.fetch_req && bus.cpu_req && !m_prev_cpu;
    check($sformatf("rnd%0d ram_we", n), 32'(bus.ram_we), 32'(cpu && bus.cpu_we));
    if (vid) check($sformatf("rnd%0d ram_addr video", n), 32'(bus.ram_addr), 32'(bus.fetch_addr));
    if (cpu) check($sformatf("rnd%0d ram_addr cpu", n), 32'(bus.ram_addr), 32'(bus.cpu_addr));
    if (cpu && bus.cpu_we)
      check($sformatf("rnd%0d ram_wdata", n), 32'(bus.ram_wdata), 32'(bus.cpu_wdata));
    if (reset) begin
      model_reset();
    end else begin
      m_prev_fetch = vid;
      m_fdata      = shadow[bus.fetch_addr];
      m_prev_cpu   = cpu;
      m_prev_we    = bus.cpu_we;
      m_cdata      = shadow[bus.cpu_addr];
      if (cpu && bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
      stalled = bus.cpu_req && !cpu;
      m_run   = stalled ? m_run + 1 : 0;
      if (m_run >= MW) m_starve = 1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic          r_req, r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    reset = 1'b1;
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = DW'(a * 13 + 7);
      shadow[a] = DW'(a * 13 + 7);
    end
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[10'h010] = 8'h77;

    // Video-only: fetches at cycles 10, 18, 26 after reset, data one cycle later.
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 30; c++) begin
      bit fr, fv;
      fr = (c == 10 || c == 18 || c == 26);
      fv = (c == 11 || c == 19 || c == 27);
      tbl.push_back(v(0, fr, AW'((c - 10) / 8), 0, 0, 0, 0, fv, DW'(8'h41 + (c - 11) / 8),
                      0, 0, 0, 0, fr, AW'((c - 10) / 8), 0));
    end
    // CPU write 0x3FF <- 0x5A, then read it back (request held through the write ack).
    tbl.push_back(v(0, 0, 0, 1, 1, 10'h3FF, 8'h5A, 0, 0, 0, 0, 0, 1, 1, 10'h3FF, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 10'h3FF, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 10'h3FF, 8'h00, 0, 0, 0, 0, 0, 0, 1, 10'h3FF, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 10'h3FF, 8'h00, 0, 0, 1, 1, 8'h5A, 0, 0, 0, 0));
    // Collision: video wins, CPU read of 0x010 served the cycle after.
    tbl.push_back(v(0, 1, 10'h001, 1, 0, 10'h010, 0, 0, 0, 0, 0, 0, 0, 1, 10'h001, 0));
    tbl.push_back(v(0, 0, 10'h001, 1, 0, 10'h010, 0, 1, 8'h42, 0, 0, 0, 0, 1, 10'h010, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 10'h010, 0, 0, 0, 1, 1, 8'h77, 0, 0, 0, 0));
    // Back-to-back: request held through the ack gives a second grant two cycles later.
    tbl.push_back(v(0, 0, 0, 1, 0, 10'h002, 0, 0, 0, 0, 0, 0, 0, 1, 10'h002, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 10'h002, 0, 0, 0, 1, 1, 8'h43, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 10'h002, 0, 0, 0, 0, 0, 0, 0, 1, 10'h002, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 10'h002, 0, 0, 0, 1, 1, 8'h43, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Abandon: CPU write loses to video, then drops its request; no access, no ack.
    tbl.push_back(v(0, 1, 10'h000, 1, 1, 10'h020, 8'hEE, 0, 0, 0, 0, 0, 0, 1, 10'h000, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 10'h020, 8'hEE, 1, 8'h41, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fr, tbl[i].fa, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd);
      check($sformatf("v%0d fetch_valid", i), 32'(bus.fetch_valid), 32'(tbl[i].e_fv));
      if (tbl[i].e_fv) check($sformatf("v%0d fetch_data", i), 32'(bus.fetch_data), 32'(tbl[i].e_fd));
      check($sformatf("v%0d cpu_ack", i), 32'(bus.cpu_ack), 32'(tbl[i].e_ack));
      if (tbl[i].chk_rd) check($sformatf("v%0d cpu_rdata", i), 32'(bus.cpu_rdata), 32'(tbl[i].e_rd));
      check($sformatf("v%0d ram_we", i), 32'(bus.ram_we), 32'(tbl[i].e_we));
      if (tbl[i].chk_addr) check($sformatf("v%0d ram_addr", i), 32'(bus.ram_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d cpu_starve", i), 32'(cpu_starve), 32'(tbl[i].e_starve));
    end

    // Starvation: video every cycle locks the CPU out; flag rises after MW stalls.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < MW; s++) begin
      drive(0, 1, 10'h005, 1, 1, 10'h040, 8'h99);
      check($sformatf("starve s%0d cpu_starve", s), 32'(cpu_starve), 32'd0);
      check($sformatf("starve s%0d ram_we", s), 32'(bus.ram_we), 32'd0);
    end
    drive(0, 1, 10'h005, 1, 1, 10'h040, 8'h99);
    check("starve set", 32'(cpu_starve), 32'd1);
    drive(0, 0, 10'h005, 1, 1, 10'h040, 8'h99);
    check("starve grant ram_we", 32'(bus.ram_we), 32'd1);
    check("starve grant ram_addr", 32'(bus.ram_addr), 32'h040);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("starve ack", 32'(bus.cpu_ack), 32'd1);
    check("starve held after ack", 32'(cpu_starve), 32'd1);
    for (int s = 0; s < 3; s++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("starve sticky %0d", s), 32'(cpu_starve), 32'd1);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    check("starve in reset", 32'(cpu_starve), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("starve after reset", 32'(cpu_starve), 32'd0);

    // Reset in the ack cycle: ack is dropped and the arbiter restarts idle.
    drive(0, 0, 0, 1, 0, 10'h002, 0);
    check("rstack grant addr", 32'(bus.ram_addr), 32'h002);
    drive(1, 1, 10'h003, 0, 0, 0, 0);
    check("rstack ack in reset", 32'(bus.cpu_ack), 32'd0);
    check("rstack we in reset", 32'(bus.ram_we), 32'd0);
    check("rstack starve in reset", 32'(cpu_starve), 32'd0);
    drive(0, 0, 0, 1, 1, 10'h030, 8'h11);
    check("rstack ack after", 32'(bus.cpu_ack), 32'd0);
    check("rstack fetch_valid after", 32'(bus.fetch_valid), 32'd0);
    check("rstack idle grant", 32'(bus.ram_we), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rstack new ack", 32'(bus.cpu_ack), 32'd1);

    // Randomized traffic on a small address window against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    r_req = 0; r_we = 0; r_addr = 10'h100; r_wdata = '0;
    for (int n = 0; n < 2000; n++) begin
      logic          rst, fr;
      logic [AW-1:0] fa;
      rst = ($urandom_range(0, 79) == 0);
      fr  = ($urandom_range(0, 2) == 0);
      fa  = 10'h100 + AW'($urandom_range(0, 15));
      if (r_req && !m_prev_cpu) begin
        if ($urandom_range(0, 9) == 0) r_req = 0;
      end else begin
        r_req   = 1'($urandom_range(0, 1));
        r_we    = 1'($urandom_range(0, 1));
        r_addr  = 10'h100 + AW'($urandom_range(0, 15));
        r_wdata = DW'($urandom);
      end
      drive(rst, fr, fa, r_req, r_we, r_addr, r_wdata);
      model_check(n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
